// File: rtl/sum_accumulator_pkg.sv
// Shared types and constants for the counter design's sum accumulator.
//   state_t     : accumulator FSM states
//   SUM_W       : adder Sum width
//   SAMPLE_W    : {overflow, sum} sample width
//   sat_add_fn  : integer saturating add, clamped to a w-bit ceiling
package counter_pkg;

  localparam int unsigned SUM_W    = 4;
  localparam int unsigned SAMPLE_W = 5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_t;

  // Saturating add of a sample onto a running total held in at most 31 bits.
  function automatic int unsigned sat_add_fn(input int unsigned a,
                                             input int unsigned b,
                                             input int unsigned w);
    longint unsigned s;
    longint unsigned lim;
    s   = longint'(a) + longint'(b);
    lim = (64'(1) << w) - 64'(1);
    return (s > lim) ? int'(lim) : int'(s);
  endfunction

endpackage

// File: rtl/sum_accumulator_if.sv
// Sample input and result output bundle of the sum accumulator.
//   master : sample source / result consumer (drives clear, en, sum, overflow, out_ready)
//   slave  : the accumulator (drives out_valid, out_total, out_ovf_cnt, out_sat, out_missed)
interface sum_accumulator_if #(
  parameter int unsigned WINDOW = 8,
  parameter int unsigned ACC_W  = 8
);
  import counter_pkg::*;

  localparam int unsigned CNT_W = $clog2(WINDOW + 1);

  logic             clear;
  logic             en;
  logic [SUM_W-1:0] sum;
  logic             overflow;
  logic             out_ready;
  logic             out_valid;
  logic [ACC_W-1:0] out_total;
  logic [CNT_W-1:0] out_ovf_cnt;
  logic             out_sat;
  logic             out_missed;

  modport master (
    output clear, en, sum, overflow, out_ready,
    input  out_valid, out_total, out_ovf_cnt, out_sat, out_missed
  );

  modport slave (
    input  clear, en, sum, overflow, out_ready,
    output out_valid, out_total, out_ovf_cnt, out_sat, out_missed
  );

endinterface

// File: rtl/sum_accumulator_sat_add.sv
// Combinational ACC_W + SAMPLE_W saturating adder.
//   a       : running total
//   b       : 5-bit sample value
//   total_c : min(a + b, 2^ACC_W - 1)
//   sat_c   : the unclamped sum did not fit in ACC_W bits
module sat_add
  import counter_pkg::*;
#(
  parameter int unsigned ACC_W = 8
) (
  input  logic [ACC_W-1:0]    a,
  input  logic [SAMPLE_W-1:0] b,
  output logic [ACC_W-1:0]    total_c,
  output logic                sat_c
);

  localparam int unsigned WIDE_W = ACC_W + 1;

  logic [WIDE_W-1:0] sum_w;

  // One extra bit catches the carry that triggers clamping.
  always_comb begin
    sum_w   = {1'b0, a} + WIDE_W'(b);
    sat_c   = sum_w[ACC_W];
    total_c = sat_c ? {ACC_W{1'b1}} : sum_w[ACC_W-1:0];
  end

endmodule

// File: rtl/sum_accumulator.sv
// Windowed accumulator of adder samples with a held valid/ready result.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : sample inputs (clear, en, sum, overflow), result handshake
//                (out_ready/out_valid) and result fields (out_total,
//                out_ovf_cnt, out_sat, out_missed)
module sum_accumulator
  import counter_pkg::*;
#(
  parameter int unsigned WINDOW = 8,
  parameter int unsigned ACC_W  = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  sum_accumulator_if.slave   bus
);

  localparam int unsigned CNT_W = $clog2(WINDOW + 1);

  state_t state, state_nxt;

  logic [ACC_W-1:0]    acc;
  logic [CNT_W-1:0]    cnt;
  logic [CNT_W-1:0]    ovf_cnt;
  logic                sat;
  logic                missed;

  logic [SAMPLE_W-1:0] value_c;
  logic [ACC_W-1:0]    add_a_c;
  logic [ACC_W-1:0]    add_total_c;
  logic                add_sat_c;
  logic [CNT_W-1:0]    cnt_inc_c;
  logic [CNT_W-1:0]    ovf_inc_c;
  logic                hs_c;
  logic                start_c;
  logic                accept_c;
  logic                latch_c;
  logic                drop_c;

  assign value_c   = {bus.overflow, bus.sum};
  assign cnt_inc_c = cnt + CNT_W'(1);
  assign ovf_inc_c = ovf_cnt + CNT_W'(bus.overflow);
  assign hs_c      = bus.out_valid & bus.out_ready;
  // A new window always starts from zero, whatever acc currently holds.
  assign add_a_c   = start_c ? '0 : acc;

  sat_add #(.ACC_W(ACC_W)) u_sat_add (
    .a       (add_a_c),
    .b       (value_c),
    .total_c (add_total_c),
    .sat_c   (add_sat_c)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next state and per-cycle datapath strobes.
  always_comb begin
    state_nxt = state;
    start_c   = 1'b0;
    accept_c  = 1'b0;
    latch_c   = 1'b0;
    drop_c    = 1'b0;
    if (bus.clear) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (bus.en) begin
            start_c   = 1'b1;
            state_nxt = ACCUM;
          end
        end
        ACCUM: begin
          if (bus.en) begin
            accept_c = 1'b1;
            if (cnt_inc_c == CNT_W'(WINDOW)) begin
              latch_c   = 1'b1;
              state_nxt = HOLD;
            end
          end
        end
        HOLD: begin
          if (hs_c) begin
            start_c   = bus.en;
            state_nxt = bus.en ? ACCUM : IDLE;
          end else if (bus.en) begin
            drop_c = 1'b1;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Window accumulators and the held result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc             <= '0;
      cnt             <= '0;
      ovf_cnt         <= '0;
      sat             <= 1'b0;
      missed          <= 1'b0;
      bus.out_valid   <= 1'b0;
      bus.out_total   <= '0;
      bus.out_ovf_cnt <= '0;
      bus.out_sat     <= 1'b0;
      bus.out_missed  <= 1'b0;
    end else if (bus.clear) begin
      acc           <= '0;
      cnt           <= '0;
      ovf_cnt       <= '0;
      sat           <= 1'b0;
      missed        <= 1'b0;
      bus.out_valid <= 1'b0;
    end else begin
      if (start_c) begin
        acc     <= add_total_c;
        cnt     <= CNT_W'(1);
        ovf_cnt <= CNT_W'(bus.overflow);
        sat     <= add_sat_c;
      end else if (latch_c) begin
        acc             <= '0;
        cnt             <= '0;
        ovf_cnt         <= '0;
        sat             <= 1'b0;
        bus.out_total   <= add_total_c;
        bus.out_ovf_cnt <= ovf_inc_c;
        bus.out_sat     <= sat | add_sat_c;
        // Drops since the previous latch belong to this result.
        bus.out_missed  <= missed;
        missed          <= 1'b0;
        bus.out_valid   <= 1'b1;
      end else if (accept_c) begin
        acc     <= add_total_c;
        cnt     <= cnt_inc_c;
        ovf_cnt <= ovf_inc_c;
        sat     <= sat | add_sat_c;
      end
      if (drop_c) missed <= 1'b1;
      if (hs_c)   bus.out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_sum_accumulator.sv
// Scoreboarded bench for sum_accumulator: a queue-based window model feeds
// expected results; a negedge monitor checks each handshaken result and
// result stability while held. A second instance covers saturation.
module tb_sum_accumulator;

  localparam int WIN  = 8;
  localparam int AW   = 8;
  localparam int MAXA = (1 << AW) - 1;

  typedef struct {
    int total;
    int ovf;
    int sat;
    int missed;
  } exp_t;

  logic clk;
  logic rst_n;

  sum_accumulator_if #(.WINDOW(WIN), .ACC_W(AW)) bus ();
  sum_accumulator_if #(.WINDOW(4), .ACC_W(6))    bus_s ();

  sum_accumulator #(.WINDOW(WIN), .ACC_W(AW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  sum_accumulator #(.WINDOW(4), .ACC_W(6)) dut_s (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_s)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_chk;
  int n_fail;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: the open window is a list of sample values.
  int   win_q[$];
  exp_t exp_q[$];
  bit   m_hold;
  bit   m_drop;

  task automatic model(input bit e, input int v, input bit r, input bit c);
    exp_t x;
    int   tot;
    if (c) begin
      if (m_hold && !r) void'(exp_q.pop_back());
      m_hold = 0;
      m_drop = 0;
      win_q.delete();
    end else if (m_hold) begin
      if (r) begin
        m_hold = 0;
        if (e) win_q.push_back(v);
      end else if (e) begin
        m_drop = 1;
      end
    end else if (e) begin
      win_q.push_back(v);
      if (win_q.size() == WIN) begin
        tot   = 0;
        x.ovf = 0;
        foreach (win_q[i]) begin
          tot += win_q[i];
          if (win_q[i] >= 16) x.ovf++;
        end
        x.sat    = (tot > MAXA) ? 1 : 0;
        x.total  = x.sat ? MAXA : tot;
        x.missed = m_drop ? 1 : 0;
        exp_q.push_back(x);
        win_q.delete();
        m_drop = 0;
        m_hold = 1;
      end
    end
  endtask

  task automatic model_reset();
    win_q.delete();
    exp_q.delete();
    m_hold = 0;
    m_drop = 0;
  endtask

  // Apply one cycle of inputs (called at posedge+1), then check out_valid.
  task automatic step(input bit e, input int s, input bit o, input bit r, input bit c);
    bus.en        = e;
    bus.sum       = 4'(s);
    bus.overflow  = o;
    bus.out_ready = r;
    bus.clear     = c;
    model(e, (o ? 16 : 0) + s, r, c);
    @(posedge clk);
    #1;
    chk("out_valid", int'(bus.out_valid), int'(m_hold));
  endtask

  // Monitor: compare each handshaken result; check held results stay put.
  bit   prev_held;
  exp_t snap;

  initial begin
    exp_t x;
    prev_held = 0;
    forever begin
      @(negedge clk);
      if (rst_n && bus.out_valid) begin
        if (prev_held) begin
          chk("hold_total", int'(bus.out_total), snap.total);
          chk("hold_ovf_cnt", int'(bus.out_ovf_cnt), snap.ovf);
          chk("hold_missed", int'(bus.out_missed), snap.missed);
        end
        if (bus.out_ready) begin
          if (exp_q.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL scoreboard: result handshaken, got total=%0d, expected no result",
                     bus.out_total);
          end else begin
            x = exp_q.pop_front();
            chk("sb_total", int'(bus.out_total), x.total);
            chk("sb_ovf_cnt", int'(bus.out_ovf_cnt), x.ovf);
            chk("sb_sat", int'(bus.out_sat), x.sat);
            chk("sb_missed", int'(bus.out_missed), x.missed);
          end
        end
      end
      prev_held   = rst_n && bus.out_valid && !bus.out_ready;
      snap.total  = int'(bus.out_total);
      snap.ovf    = int'(bus.out_ovf_cnt);
      snap.missed = int'(bus.out_missed);
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_chk  = 0;
    n_fail = 0;
    model_reset();
    rst_n = 1'b0;
    {bus.en, bus.sum, bus.overflow, bus.out_ready, bus.clear} = '0;
    {bus_s.en, bus_s.sum, bus_s.overflow, bus_s.out_ready, bus_s.clear} = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", int'(bus.out_valid), 0);
    chk("rst_total", int'(bus.out_total), 0);
    chk("rst_s_valid", int'(bus_s.out_valid), 0);
    rst_n = 1'b1;

    // Idle after reset: nothing ever appears.
    for (int i = 0; i < 20; i++) begin
      step(0, 0, 0, 0, 0);
      chk("idle_total", int'(bus.out_total), 0);
      chk("idle_ovf_cnt", int'(bus.out_ovf_cnt), 0);
      chk("idle_sat", int'(bus.out_sat), 0);
      chk("idle_missed", int'(bus.out_missed), 0);
    end

    // Nominal window: 8 x value 19.
    for (int i = 0; i < WIN; i++) step(1, 3, 1, 1, 0);
    chk("nom_total", int'(bus.out_total), 152);
    chk("nom_ovf_cnt", int'(bus.out_ovf_cnt), 8);
    chk("nom_sat", int'(bus.out_sat), 0);
    chk("nom_missed", int'(bus.out_missed), 0);
    step(0, 0, 0, 1, 0);

    // Saturation on the narrow instance: 4 x 19 clamps to 63.
    bus_s.en = 1'b1; bus_s.sum = 4'd3; bus_s.overflow = 1'b1;
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 0);
    bus_s.en = 1'b0;
    chk("sat_valid", int'(bus_s.out_valid), 1);
    chk("sat_total", int'(bus_s.out_total), 63);
    chk("sat_flag", int'(bus_s.out_sat), 1);
    chk("sat_ovf_cnt", int'(bus_s.out_ovf_cnt), 4);
    bus_s.out_ready = 1'b1;
    step(0, 0, 0, 0, 0);
    bus_s.out_ready = 1'b0;
    chk("sat_valid_taken", int'(bus_s.out_valid), 0);

    // Back-pressure with drops, then handshake that starts window 2.
    for (int i = 0; i < WIN; i++) step(1, 5, 0, 0, 0);
    for (int i = 0; i < 5; i++) step((i % 2) == 0, 9, 1, 0, 0);
    step(1, 2, 0, 1, 0);
    for (int i = 0; i < WIN - 1; i++) step(1, 2, 0, 0, 0);
    chk("w2_total", int'(bus.out_total), 16);
    chk("w2_missed", int'(bus.out_missed), 1);
    step(1, 4, 0, 1, 0);
    for (int i = 0; i < WIN - 1; i++) step(1, 4, 0, 0, 0);
    chk("w3_total", int'(bus.out_total), 32);
    chk("w3_missed", int'(bus.out_missed), 0);
    step(0, 0, 0, 1, 0);

    // Clear mid-window, then a fresh window of ones.
    for (int i = 0; i < 5; i++) step(1, 7, 0, 0, 0);
    step(1, 7, 0, 0, 1);
    for (int i = 0; i < WIN; i++) step(1, 1, 0, 0, 0);
    chk("clr_total", int'(bus.out_total), 8);
    chk("clr_ovf_cnt", int'(bus.out_ovf_cnt), 0);

    // Asynchronous reset while a result is held.
    {bus.en, bus.out_ready} = '0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid", int'(bus.out_valid), 0);
    chk("async_rst_total", int'(bus.out_total), 0);
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Back-to-back windows with out_ready held high.
    for (int i = 0; i < 3 * WIN; i++) step(1, i % 16, i % 3 == 0, 1, 0);

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      bit c;
      c = ($urandom_range(0, 59) == 0);
      step($urandom_range(0, 9) < 7, int'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
           c ? 1'b0 : ($urandom_range(0, 9) < 6), c);
    end

    for (int i = 0; i < WIN + 4; i++) step(0, 0, 0, 1, 0);
    chk("queue_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
